// File: rtl/parametrised_set_associative_cache.sv
`default_nettype none
// =============================================================================
// Module   : parametrised_set_associative_cache
// Brief    : Set-associative tag/state/data store with CPU and snoopy lookup
//            ports and tree pseudo-LRU replacement. Defining
//            PARAMETRISED_SET_ASSOCIATIVE_CACHE_RANDOM_REPLACEMENT_EN swaps the
//            PLRU tree for an LFSR victim.
// Revision : 1.0
// =============================================================================
module parametrised_set_associative_cache #(
   parameter int TAG_WIDTH      = 6,
   parameter int INDEX_WIDTH    = 4,
   parameter int OFFSET_WIDTH   = 2,
   parameter int DATA_WIDTH     = 16,
   parameter int NUMBER_OF_WAYS = 4,
   parameter type STATE_TYPE    = logic [1:0],
   parameter STATE_TYPE INVALID_STATE = 2'b0,
   localparam int WAY_BITS      = $clog2(NUMBER_OF_WAYS)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cpuRequest,
   output logic                    cpuReady,
   input  logic [TAG_WIDTH-1:0]    cpuTagIn,
   input  logic [INDEX_WIDTH-1:0]  cpuIndex,
   input  logic [OFFSET_WIDTH-1:0] cpuOffset,
   input  logic [DATA_WIDTH-1:0]   cpuDataIn,
   input  STATE_TYPE               cpuStateIn,
   input  logic                    cpuWriteTag,
   input  logic                    cpuWriteData,
   input  logic                    cpuWriteState,
   output logic                    cpuValid,
   output logic                    cpuHit,
   output logic [WAY_BITS-1:0]     cpuWay,
   output logic [TAG_WIDTH-1:0]    cpuTagOut,
   output logic [DATA_WIDTH-1:0]   cpuDataOut,
   output STATE_TYPE               cpuStateOut,
   input  logic                    snoopyRequest,
   input  logic [TAG_WIDTH-1:0]    snoopyTagIn,
   input  logic [INDEX_WIDTH-1:0]  snoopyIndex,
   input  logic                    snoopyWriteState,
   input  STATE_TYPE               snoopyStateIn,
   output logic                    snoopyValid,
   output logic                    snoopyHit,
   output logic [WAY_BITS-1:0]     snoopyWay,
   output STATE_TYPE               snoopyStateOut
);

   localparam int SETS  = 1 << INDEX_WIDTH;
   localparam int WORDS = 1 << OFFSET_WIDTH;
   localparam logic [INDEX_WIDTH:0] LAST_SET = (INDEX_WIDTH+1)'(SETS - 1);

   typedef enum logic {INIT = 1'b0, READY = 1'b1} fsm_t;

   fsm_t                   fsm, fsm_next;
   logic [INDEX_WIDTH:0]   sweep_count;

   logic [TAG_WIDTH-1:0]   tag_mem   [SETS][NUMBER_OF_WAYS];
   STATE_TYPE              state_mem [SETS][NUMBER_OF_WAYS];
   logic [DATA_WIDTH-1:0]  data_mem  [SETS][NUMBER_OF_WAYS][WORDS];

   logic                   cpu_accept, snp_accept;
   logic                   cpu_hit, cpu_inv_found, snp_hit;
   logic [WAY_BITS-1:0]    cpu_hit_way, cpu_inv_way, cpu_sel_way, victim_way, snp_hit_way;

   always_ff @(posedge clock) begin
      if (reset) begin
         fsm         <= INIT;
         sweep_count <= '0;
      end else begin
         fsm <= fsm_next;
         if (fsm == INIT) sweep_count <= sweep_count + (INDEX_WIDTH+1)'(1);
      end
   end

   always_comb begin
      fsm_next = fsm;
      case (fsm)
         INIT:    if (sweep_count == LAST_SET) fsm_next = READY;
         default: fsm_next = READY;
      endcase
   end

   assign cpuReady   = (fsm == READY);
   assign cpu_accept = cpuRequest && cpuReady && !reset;
   assign snp_accept = snoopyRequest && cpuReady && !reset;

   always_comb begin
      cpu_hit       = 1'b0;
      cpu_hit_way   = '0;
      cpu_inv_found = 1'b0;
      cpu_inv_way   = '0;
      snp_hit       = 1'b0;
      snp_hit_way   = '0;
      // Descending scan leaves the lowest-numbered invalid way selected.
      for (int w = NUMBER_OF_WAYS - 1; w >= 0; w--) begin
         if (state_mem[cpuIndex][w] == INVALID_STATE) begin
            cpu_inv_found = 1'b1;
            cpu_inv_way   = WAY_BITS'(w);
         end else if (tag_mem[cpuIndex][w] == cpuTagIn) begin
            cpu_hit     = 1'b1;
            cpu_hit_way = cpu_hit_way | WAY_BITS'(w);
         end
         if (state_mem[snoopyIndex][w] != INVALID_STATE &&
             tag_mem[snoopyIndex][w] == snoopyTagIn) begin
            snp_hit     = 1'b1;
            snp_hit_way = snp_hit_way | WAY_BITS'(w);
         end
      end
      cpu_sel_way = cpu_hit ? cpu_hit_way : (cpu_inv_found ? cpu_inv_way : victim_way);
   end

`ifdef PARAMETRISED_SET_ASSOCIATIVE_CACHE_RANDOM_REPLACEMENT_EN
   logic [15:0] lfsr;

   always_ff @(posedge clock) begin
      if (reset)
         lfsr <= 16'hACE1;
      else if (cpu_accept && !cpu_hit)
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   assign victim_way = lfsr[WAY_BITS-1:0];
`else
   // Heap-ordered tree: node n has children 2n and 2n+1; a bit of 1 points right.
   logic [NUMBER_OF_WAYS-1:1] plru [SETS];
   logic [NUMBER_OF_WAYS-1:1] plru_upd;
   int                        vnode, unode;

   always_comb begin
      vnode = 1;
      for (int l = 0; l < WAY_BITS; l++) vnode = 2 * vnode + int'(plru[cpuIndex][vnode]);
      victim_way = WAY_BITS'(vnode - NUMBER_OF_WAYS);
      plru_upd   = plru[cpuIndex];
      unode      = 1;
      for (int l = 0; l < WAY_BITS; l++) begin
         plru_upd[unode] = ~cpu_sel_way[WAY_BITS-1-l];
         unode           = 2 * unode + int'(cpu_sel_way[WAY_BITS-1-l]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) plru[s] <= '0;
      end else if (cpu_accept) begin
         plru[cpuIndex] <= plru_upd;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (cpu_accept && cpuWriteTag)  tag_mem[cpuIndex][cpu_sel_way] <= cpuTagIn;
      if (cpu_accept && cpuWriteData) data_mem[cpuIndex][cpu_sel_way][cpuOffset] <= cpuDataIn;
   end

   // Snoopy write is last so it wins a same-line collision with the CPU.
   always_ff @(posedge clock) begin
      if (fsm == INIT) begin
         for (int w = 0; w < NUMBER_OF_WAYS; w++)
            state_mem[sweep_count[INDEX_WIDTH-1:0]][w] <= INVALID_STATE;
      end
      if (cpu_accept && cpuWriteState) state_mem[cpuIndex][cpu_sel_way] <= cpuStateIn;
      if (snp_accept && snoopyWriteState && snp_hit)
         state_mem[snoopyIndex][snp_hit_way] <= snoopyStateIn;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cpuValid       <= 1'b0;
         cpuHit         <= 1'b0;
         cpuWay         <= '0;
         cpuTagOut      <= '0;
         cpuDataOut     <= '0;
         cpuStateOut    <= '0;
         snoopyValid    <= 1'b0;
         snoopyHit      <= 1'b0;
         snoopyWay      <= '0;
         snoopyStateOut <= '0;
      end else begin
         cpuValid    <= cpu_accept;
         snoopyValid <= snp_accept;
         if (cpu_accept) begin
            cpuHit      <= cpu_hit;
            cpuWay      <= cpu_sel_way;
            cpuTagOut   <= tag_mem[cpuIndex][cpu_sel_way];
            cpuDataOut  <= data_mem[cpuIndex][cpu_sel_way][cpuOffset];
            cpuStateOut <= state_mem[cpuIndex][cpu_sel_way];
         end
         if (snp_accept) begin
            snoopyHit      <= snp_hit;
            snoopyWay      <= snp_hit_way;
            snoopyStateOut <= state_mem[snoopyIndex][snp_hit_way];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_parametrised_set_associative_cache.sv
`default_nettype none
// =============================================================================
// Module   : tb_parametrised_set_associative_cache
// Brief    : Scoreboard bench for parametrised_set_associative_cache.
// Revision : 1.0
// =============================================================================
module tb_parametrised_set_associative_cache;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpuRequest = 1'b0, cpuReady;
   logic [5:0]  cpuTagIn = '0;
   logic [3:0]  cpuIndex = '0;
   logic [1:0]  cpuOffset = '0;
   logic [15:0] cpuDataIn = '0;
   logic [1:0]  cpuStateIn = '0;
   logic        cpuWriteTag = 1'b0, cpuWriteData = 1'b0, cpuWriteState = 1'b0;
   logic        cpuValid, cpuHit;
   logic [1:0]  cpuWay;
   logic [5:0]  cpuTagOut;
   logic [15:0] cpuDataOut;
   logic [1:0]  cpuStateOut;
   logic        snoopyRequest = 1'b0;
   logic [5:0]  snoopyTagIn = '0;
   logic [3:0]  snoopyIndex = '0;
   logic        snoopyWriteState = 1'b0;
   logic [1:0]  snoopyStateIn = '0;
   logic        snoopyValid, snoopyHit;
   logic [1:0]  snoopyWay;
   logic [1:0]  snoopyStateOut;

   parametrised_set_associative_cache dut (
      .clock(clock), .reset(reset),
      .cpuRequest(cpuRequest), .cpuReady(cpuReady), .cpuTagIn(cpuTagIn),
      .cpuIndex(cpuIndex), .cpuOffset(cpuOffset), .cpuDataIn(cpuDataIn),
      .cpuStateIn(cpuStateIn), .cpuWriteTag(cpuWriteTag), .cpuWriteData(cpuWriteData),
      .cpuWriteState(cpuWriteState), .cpuValid(cpuValid), .cpuHit(cpuHit),
      .cpuWay(cpuWay), .cpuTagOut(cpuTagOut), .cpuDataOut(cpuDataOut),
      .cpuStateOut(cpuStateOut), .snoopyRequest(snoopyRequest),
      .snoopyTagIn(snoopyTagIn), .snoopyIndex(snoopyIndex),
      .snoopyWriteState(snoopyWriteState), .snoopyStateIn(snoopyStateIn),
      .snoopyValid(snoopyValid), .snoopyHit(snoopyHit), .snoopyWay(snoopyWay),
      .snoopyStateOut(snoopyStateOut)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        hit;
      logic [1:0]  way;
      logic [5:0]  tag;
      logic [15:0] data;
      logic [1:0]  state;
      bit          ck_tag;
      bit          ck_data;
   } resp_t;

   resp_t       cpu_q[$];
   resp_t       snp_q[$];
   resp_t       ce, se;
   int          compared   = 0;
   int          mismatched = 0;
   logic [15:0] lfsr_m     = 16'hACE1;
   logic [1:0]  victim_exp;
   int          init_len;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cpu_drive(input logic [5:0] t, input logic [3:0] idx, input logic [1:0] off,
                            input logic [15:0] din, input logic [1:0] sin,
                            input logic wt, input logic wd, input logic ws,
                            input logic ehit, input logic [1:0] eway, input logic [5:0] etag,
                            input logic [15:0] edata, input logic [1:0] estate,
                            input bit ck_tag, input bit ck_data);
      resp_t r;
      cpuTagIn = t; cpuIndex = idx; cpuOffset = off; cpuDataIn = din; cpuStateIn = sin;
      cpuWriteTag = wt; cpuWriteData = wd; cpuWriteState = ws; cpuRequest = 1'b1;
      r.hit = ehit; r.way = eway; r.tag = etag; r.data = edata; r.state = estate;
      r.ck_tag = ck_tag; r.ck_data = ck_data;
      cpu_q.push_back(r);
      if (!ehit) lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
   endtask

   task automatic snp_drive(input logic [5:0] t, input logic [3:0] idx, input logic ws,
                            input logic [1:0] sin, input logic ehit, input logic [1:0] eway,
                            input logic [1:0] estate);
      resp_t r;
      snoopyTagIn = t; snoopyIndex = idx; snoopyWriteState = ws; snoopyStateIn = sin;
      snoopyRequest = 1'b1;
      r.hit = ehit; r.way = eway; r.tag = '0; r.data = '0; r.state = estate;
      r.ck_tag = 1'b0; r.ck_data = 1'b0;
      snp_q.push_back(r);
   endtask

   task automatic tick();
      @(negedge clock);
      cpuRequest = 1'b0; snoopyRequest = 1'b0;
      cpuWriteTag = 1'b0; cpuWriteData = 1'b0; cpuWriteState = 1'b0; snoopyWriteState = 1'b0;
   endtask

   task automatic measure_init(output int n);
      n = 0;
      while (!cpuReady && n < 40) begin
         n++;
         @(negedge clock);
      end
   endtask

   // Every queued expectation must be answered on the edge right after it was driven.
   always @(posedge clock) begin
      #1;
      if (cpu_q.size() != 0) begin
         ce = cpu_q.pop_front();
         check("cpu_valid", cpuValid, 1);
         check("cpu_hit", cpuHit, ce.hit);
         check("cpu_way", cpuWay, ce.way);
         check("cpu_state", cpuStateOut, ce.state);
         if (ce.ck_tag)  check("cpu_tag", cpuTagOut, ce.tag);
         if (ce.ck_data) check("cpu_data", cpuDataOut, ce.data);
      end else if (cpuValid) begin
         check("cpu_unexpected_valid", cpuValid, 0);
      end
      if (snp_q.size() != 0) begin
         se = snp_q.pop_front();
         check("snp_valid", snoopyValid, 1);
         check("snp_hit", snoopyHit, se.hit);
         check("snp_way", snoopyWay, se.way);
         check("snp_state", snoopyStateOut, se.state);
      end else if (snoopyValid) begin
         check("snp_unexpected_valid", snoopyValid, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Reset values, then sweep length with snoopy requests that must be ignored.
      @(negedge clock);
      check("rst_ready", cpuReady, 0);
      check("rst_cpu_valid", cpuValid, 0);
      check("rst_snp_valid", snoopyValid, 0);
      check("rst_cpu_hit", cpuHit, 0);
      check("rst_cpu_way", cpuWay, 0);
      check("rst_cpu_state", cpuStateOut, 0);
      reset = 1'b0;
      snoopyRequest = 1'b1;
      measure_init(init_len);
      snoopyRequest = 1'b0;
      check("init_len", init_len, 16);

      for (int s = 0; s < 16; s++) begin
         cpu_drive(6'h00, 4'(s), 2'd0, 16'h0, 2'b00, 0, 0, 0,
                   0, 2'd0, 6'h0, 16'h0, 2'b00, 0, 0);
         tick();
      end

      // Fill set 3 back-to-back; each miss must land in the next invalid way.
      for (int w = 0; w < 4; w++) begin
         cpu_drive(6'(w + 1), 4'd3, 2'(w), 16'h1000 + 16'(w), 2'b01, 1, 1, 1,
                   0, 2'(w), 6'h0, 16'h0, 2'b00, 0, 0);
         tick();
      end
      cpu_drive(6'h03, 4'd3, 2'd2, 16'h0, 2'b00, 0, 0, 0,
                1, 2'd2, 6'h03, 16'h1002, 2'b01, 1, 1);
      tick();

      for (int w = 0; w < 4; w++) begin
         cpu_drive(6'(w + 1), 4'd3, 2'(w), 16'h0, 2'b00, 0, 0, 0,
                   1, 2'(w), 6'(w + 1), 16'h1000 + 16'(w), 2'b01, 1, 1);
         tick();
      end
`ifdef PARAMETRISED_SET_ASSOCIATIVE_CACHE_RANDOM_REPLACEMENT_EN
      victim_exp = lfsr_m[1:0];
`else
      victim_exp = 2'd0;
`endif
      cpu_drive(6'h10, 4'd3, 2'd0, 16'h0, 2'b00, 0, 0, 0,
                0, victim_exp, 6'(victim_exp) + 6'd1, 16'h0, 2'b01, 1, 0);
      tick();

      // Snoopy invalidate, then invalid-first selection on the next CPU miss.
      snp_drive(6'h02, 4'd3, 1, 2'b00, 1, 2'd1, 2'b01);
      tick();
      cpu_drive(6'h20, 4'd3, 2'd0, 16'h0, 2'b01, 1, 0, 1,
                0, 2'd1, 6'h02, 16'h0, 2'b00, 1, 0);
      tick();

      // Collision on the same line: snoopy state write wins.
      cpu_drive(6'h20, 4'd3, 2'd0, 16'h0, 2'b11, 0, 0, 1,
                1, 2'd1, 6'h20, 16'h0, 2'b01, 1, 0);
      snp_drive(6'h20, 4'd3, 1, 2'b10, 1, 2'd1, 2'b01);
      tick();
      cpu_drive(6'h20, 4'd3, 2'd0, 16'h0, 2'b00, 0, 0, 0,
                1, 2'd1, 6'h20, 16'h0, 2'b10, 1, 0);
      snp_drive(6'h20, 4'd3, 0, 2'b00, 1, 2'd1, 2'b10);
      tick();
      tick();

      // Reset at sweep cycle 7 restarts the full sweep.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (7) @(negedge clock);
      check("mid_sweep_ready", cpuReady, 0);
      reset = 1'b1;
      lfsr_m = 16'hACE1;
      @(negedge clock);
      reset = 1'b0;
      measure_init(init_len);
      check("restart_init_len", init_len, 16);
      cpu_drive(6'h01, 4'd3, 2'd0, 16'h0, 2'b00, 0, 0, 0,
                0, 2'd0, 6'h0, 16'h0, 2'b00, 0, 0);
      tick();
      repeat (3) @(negedge clock);
      check("cpu_q_drained", cpu_q.size(), 0);
      check("snp_q_drained", snp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
